plab1_imul_mul_arbiter: RTL and testbench

PLAB1_IMUL_MUL_ARBITER -- requirements
Module: plab1_imul_MulArbiter

---
 rtl/plab1_imul_mul_arbiter_pkg.sv | 33 +++
 rtl/plab1_imul_mul_arbiter_rr2.sv | 56 +++++
 rtl/plab1_imul_mul_arbiter.sv | 112 +++++++++++
 tb/tb_plab1_imul_mul_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plab1_imul_mul_arbiter_pkg.sv
// Shared imul message layout, arbiter state encoding and requester port indices.
package plab1_imul_mul_arbiter_pkg;

  localparam int unsigned IMUL_FUNC_NBITS = 3;
  localparam int unsigned IMUL_OP_NBITS   = 32;
  localparam int unsigned IMUL_REQ_NBITS  = IMUL_FUNC_NBITS + 2 * IMUL_OP_NBITS;
  localparam int unsigned IMUL_RESP_NBITS = 32;

  localparam logic [IMUL_FUNC_NBITS-1:0] IMUL_FUNC_MUL = 3'd0;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [IMUL_FUNC_NBITS-1:0] func;
    logic [IMUL_OP_NBITS-1:0]   a;
    logic [IMUL_OP_NBITS-1:0]   b;
  } imul_req_t;

  function automatic logic [IMUL_REQ_NBITS-1:0] imul_req_mk(
    input logic [IMUL_FUNC_NBITS-1:0] func,
    input logic [IMUL_OP_NBITS-1:0]   a,
    input logic [IMUL_OP_NBITS-1:0]   b
  );
    return {func, a, b};
  endfunction

endpackage

// File: rtl/plab1_imul_mul_arbiter_rr2.sv
// Two-way grant logic with a latch that freezes the grant while an issue is stalled.
// Round-robin pointer exists only when PLAB1_IMUL_ARB_ROUND_ROBIN_EN is defined.
module plab1_imul_mul_arbiter_rr2
  import plab1_imul_mul_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0_val,
  input  logic req1_val,
  input  logic hold,
  input  logic adv,
  input  logic adv_owner,
  output logic grant
);

  logic latch_vld;
  logic latch_grant;
  logic pick;

`ifdef PLAB1_IMUL_ARB_ROUND_ROBIN_EN
  logic ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   ptr <= PORT0;
    else if (adv) ptr <= ~adv_owner;
  end

  always_comb begin
    pick = PORT0;
    if (req0_val && req1_val) pick = ptr;
    else if (req1_val)        pick = PORT1;
  end
`else
  logic unused_adv;
  assign unused_adv = adv ^ adv_owner;

  always_comb begin
    pick = PORT0;
    if (!req0_val && req1_val) pick = PORT1;
  end
`endif

  // A stalled issue keeps its grant so the offered payload cannot change under the multiplier.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latch_vld   <= 1'b0;
      latch_grant <= PORT0;
    end else begin
      latch_vld   <= hold;
      latch_grant <= grant;
    end
  end

  assign grant = latch_vld ? latch_grant : pick;

endmodule

// File: rtl/plab1_imul_mul_arbiter.sv
// Shares one multiplier between two requesters, one transaction outstanding at a time.
// PLAB1_IMUL_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed requester-0 priority.
module plab1_imul_mul_arbiter
  import plab1_imul_mul_arbiter_pkg::*;
#(
  parameter int unsigned p_req_nbits  = IMUL_REQ_NBITS,
  parameter int unsigned p_resp_nbits = IMUL_RESP_NBITS
)
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0_val,
  output logic                    req0_rdy,
  input  logic [p_req_nbits-1:0]  req0_msg,
  input  logic                    req1_val,
  output logic                    req1_rdy,
  input  logic [p_req_nbits-1:0]  req1_msg,
  output logic                    resp0_val,
  input  logic                    resp0_rdy,
  output logic [p_resp_nbits-1:0] resp0_msg,
  output logic                    resp1_val,
  input  logic                    resp1_rdy,
  output logic [p_resp_nbits-1:0] resp1_msg,
  output logic                    mul_domain,
  output logic                    mul_in_val,
  input  logic                    mul_in_rdy,
  output logic [p_req_nbits-1:0]  mul_in_msg,
  input  logic                    mul_out_val,
  output logic                    mul_out_rdy,
  input  logic [p_resp_nbits-1:0] mul_out_msg
);

  arb_state_t state, state_next;
  logic       owner;
  logic       grant;
  logic       req_go;
  logic       resp_go;
  logic       hold;

  assign req_go  = (state == IDLE) && mul_in_val && mul_in_rdy;
  assign resp_go = (state == BUSY) && mul_out_val && mul_out_rdy;
  assign hold    = (state == IDLE) && mul_in_val && !mul_in_rdy;

  plab1_imul_mul_arbiter_rr2 u_grant (
    .clk       (clk),
    .reset     (reset),
    .req0_val  (req0_val),
    .req1_val  (req1_val),
    .hold      (hold),
    .adv       (resp_go),
    .adv_owner (owner),
    .grant     (grant)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= PORT0;
    end else begin
      state <= state_next;
      if (req_go) owner <= grant;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_go)  state_next = BUSY;
      BUSY:    if (resp_go) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, independent of the live inputs.
  always_comb begin
    req0_rdy    = 1'b0;
    req1_rdy    = 1'b0;
    resp0_val   = 1'b0;
    resp1_val   = 1'b0;
    resp0_msg   = '0;
    resp1_msg   = '0;
    mul_domain  = PORT0;
    mul_in_val  = 1'b0;
    mul_in_msg  = '0;
    mul_out_rdy = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          mul_domain = grant;
          mul_in_val = (grant == PORT1) ? req1_val : req0_val;
          mul_in_msg = (grant == PORT1) ? req1_msg : req0_msg;
          req0_rdy   = (grant == PORT0) && mul_in_rdy;
          req1_rdy   = (grant == PORT1) && mul_in_rdy;
        end
        BUSY: begin
          mul_domain = owner;
          if (owner == PORT1) begin
            resp1_val   = mul_out_val;
            resp1_msg   = mul_out_msg;
            mul_out_rdy = resp1_rdy;
          end else begin
            resp0_val   = mul_out_val;
            resp0_msg   = mul_out_msg;
            mul_out_rdy = resp0_rdy;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_plab1_imul_mul_arbiter.sv
// Scoreboard bench for the multiplier arbiter with a behavioural shared multiplier.
module tb_plab1_imul_mul_arbiter;
  import plab1_imul_mul_arbiter_pkg::*;

  localparam int unsigned REQ_W  = 67;
  localparam int unsigned RESP_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic              req0_val, req0_rdy, req1_val, req1_rdy;
  logic [REQ_W-1:0]  req0_msg, req1_msg, mul_in_msg;
  logic              resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic [RESP_W-1:0] resp0_msg, resp1_msg, mul_out_msg;
  logic              mul_domain, mul_in_val, mul_in_rdy, mul_out_val, mul_out_rdy;

  plab1_imul_mul_arbiter #(.p_req_nbits(REQ_W), .p_resp_nbits(RESP_W)) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
    .mul_domain(mul_domain),
    .mul_in_val(mul_in_val), .mul_in_rdy(mul_in_rdy), .mul_in_msg(mul_in_msg),
    .mul_out_val(mul_out_val), .mul_out_rdy(mul_out_rdy), .mul_out_msg(mul_out_msg)
  );

  // Shared multiplier model, reset by the same system reset as the arbiter.
  logic              m_busy, m_out, m_in_en, stray;
  logic [RESP_W-1:0] m_res;
  int unsigned       m_cnt, lat;
  imul_req_t         mr;

  assign mr          = imul_req_t'(mul_in_msg);
  assign mul_in_rdy  = !m_busy && m_in_en;
  assign mul_out_val = m_out | stray;
  assign mul_out_msg = m_res;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_out  <= 1'b0;
      m_cnt  <= 0;
      m_res  <= '0;
    end else if (!m_busy && mul_in_val && mul_in_rdy) begin
      m_busy <= 1'b1;
      m_cnt  <= lat;
      m_res  <= mr.a * mr.b;
    end else if (m_busy && !m_out) begin
      if (m_cnt <= 1) m_out <= 1'b1;
      else            m_cnt <= m_cnt - 1;
    end else if (m_out && mul_out_rdy) begin
      m_out  <= 1'b0;
      m_busy <= 1'b0;
    end
  end

  int unsigned      total = 0;
  int unsigned      bad = 0;
  logic [REQ_W-1:0] q0[$], q1[$];
  logic [31:0]      exp0[$], exp1[$];
  logic             served[$];
  logic             en0, en1, outstanding, tb_owner;

  function automatic logic [31:0] prod(input logic [REQ_W-1:0] m);
    imul_req_t r;
    r = imul_req_t'(m);
    return r.a * r.b;
  endfunction

  task automatic drive();
    req0_val = en0 && (q0.size() != 0);
    req0_msg = (q0.size() != 0) ? q0[0] : '0;
    req1_val = en1 && (q1.size() != 0);
    req1_msg = (q1.size() != 0) ? q1[0] : '0;
  endtask

  // One clock: observe at the falling edge, update requesters just after the rising edge.
  task automatic cycle();
    logic go0, go1;
    logic [31:0] e;
    go0 = 1'b0;
    go1 = 1'b0;
    @(negedge clk);
    if (outstanding) begin
      total++;
      if ({mul_in_val, req0_rdy, req1_rdy} !== 3'b000) begin
        bad++; $display("FAIL busy_quiet: got %b want 000", {mul_in_val, req0_rdy, req1_rdy});
      end
      total++;
      if (mul_domain !== tb_owner) begin
        bad++; $display("FAIL domain_hold: got %b want %b", mul_domain, tb_owner);
      end
      total++;
      if (tb_owner) begin
        if ({resp1_val, mul_out_rdy, resp1_msg, resp0_val, resp0_msg} !== {mul_out_val, resp1_rdy, mul_out_msg, 1'b0, 32'h0}) begin
          bad++; $display("FAIL route1: got %b/%b/%h/%b/%h want %b/%b/%h/0/0", resp1_val, mul_out_rdy, resp1_msg, resp0_val, resp0_msg, mul_out_val, resp1_rdy, mul_out_msg);
        end
      end else begin
        if ({resp0_val, mul_out_rdy, resp0_msg, resp1_val, resp1_msg} !== {mul_out_val, resp0_rdy, mul_out_msg, 1'b0, 32'h0}) begin
          bad++; $display("FAIL route0: got %b/%b/%h/%b/%h want %b/%b/%h/0/0", resp0_val, mul_out_rdy, resp0_msg, resp1_val, resp1_msg, mul_out_val, resp0_rdy, mul_out_msg);
        end
      end
    end else begin
      total++;
      if ({mul_out_rdy, resp0_val, resp1_val, req0_rdy & req1_rdy} !== 4'b0000) begin
        bad++; $display("FAIL idle_quiet: got %b want 0000", {mul_out_rdy, resp0_val, resp1_val, req0_rdy & req1_rdy});
      end
    end
    if (resp0_val && resp0_rdy) begin
      total++;
      if (!outstanding || tb_owner || exp0.size() == 0) begin
        bad++; $display("FAIL resp0_unexpected: got resp0 %h want none", resp0_msg);
      end else begin
        e = exp0.pop_front();
        total++;
        if (resp0_msg !== e) begin
          bad++; $display("FAIL resp0_msg: got %h want %h", resp0_msg, e);
        end
        served.push_back(1'b0);
        outstanding = 1'b0;
      end
    end
    if (resp1_val && resp1_rdy) begin
      total++;
      if (!outstanding || !tb_owner || exp1.size() == 0) begin
        bad++; $display("FAIL resp1_unexpected: got resp1 %h want none", resp1_msg);
      end else begin
        e = exp1.pop_front();
        total++;
        if (resp1_msg !== e) begin
          bad++; $display("FAIL resp1_msg: got %h want %h", resp1_msg, e);
        end
        served.push_back(1'b1);
        outstanding = 1'b0;
      end
    end
    if (req0_val && req0_rdy && q0.size() != 0) begin
      total++;
      if ({mul_in_val, mul_domain, mul_in_msg} !== {1'b1, 1'b0, q0[0]}) begin
        bad++; $display("FAIL issue0: got %b/%b/%h want 1/0/%h", mul_in_val, mul_domain, mul_in_msg, q0[0]);
      end
      exp0.push_back(prod(q0[0]));
      outstanding = 1'b1;
      tb_owner = 1'b0;
      go0 = 1'b1;
    end
    if (req1_val && req1_rdy && q1.size() != 0) begin
      total++;
      if ({mul_in_val, mul_domain, mul_in_msg} !== {1'b1, 1'b1, q1[0]}) begin
        bad++; $display("FAIL issue1: got %b/%b/%h want 1/1/%h", mul_in_val, mul_domain, mul_in_msg, q1[0]);
      end
      exp1.push_back(prod(q1[0]));
      outstanding = 1'b1;
      tb_owner = 1'b1;
      go1 = 1'b1;
    end
    @(posedge clk);
    #1;
    if (go0) void'(q0.pop_front());
    if (go1) void'(q1.pop_front());
    drive();
  endtask

  task automatic run(input int unsigned budget);
    int unsigned n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || outstanding) && n < budget) begin
      cycle();
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++; $display("FAIL run_timeout: got %0d cycles want < %0d", n, budget);
    end
  endtask

  task automatic check_order(input string name, input logic exp_order[$]);
    total++;
    if (served.size() != exp_order.size()) begin
      bad++; $display("FAIL %s_count: got %0d want %0d", name, served.size(), exp_order.size());
    end else begin
      foreach (exp_order[i]) begin
        total++;
        if (served[i] !== exp_order[i]) begin
          bad++; $display("FAIL %s_order[%0d]: got %b want %b", name, i, served[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    en0 = 1'b0; en1 = 1'b0;
    q0.delete(); q1.delete(); exp0.delete(); exp1.delete(); served.delete();
    stray = 1'b0; m_in_en = 1'b1; lat = 1;
    resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    outstanding = 1'b0; tb_owner = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    q0.push_back(imul_req_mk(IMUL_FUNC_MUL, 32'd1, 32'd1));
    q1.push_back(imul_req_mk(IMUL_FUNC_MUL, 32'd2, 32'd2));
    en0 = 1'b1; en1 = 1'b1; m_in_en = 1'b1; stray = 1'b1;
    resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    drive();
    #3;
    total++;
    if ({req0_rdy, req1_rdy, resp0_val, resp1_val, mul_in_val, mul_out_rdy, mul_domain} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000000", {req0_rdy, req1_rdy, resp0_val, resp1_val, mul_in_val, mul_out_rdy, mul_domain});
    end
    total++;
    if ({resp0_msg, resp1_msg} !== 64'h0) begin
      bad++; $display("FAIL reset_msg: got %h want 0", {resp0_msg, resp1_msg});
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    lat = 3;
    q0.push_back(imul_req_mk(IMUL_FUNC_MUL, 32'd3, 32'd4));
    en0 = 1'b1;
    drive();
    run(100);
    check_order("single", '{1'b0});
  endtask

  task automatic test_simultaneous();
    do_reset();
    q0.push_back(imul_req_mk(IMUL_FUNC_MUL, 32'd5, 32'd6));
    q1.push_back(imul_req_mk(IMUL_FUNC_MUL, 32'd7, 32'd8));
    en0 = 1'b1; en1 = 1'b1;
    drive();
    run(100);
    check_order("simul", '{1'b0, 1'b1});
  endtask

  task automatic test_contention();
    do_reset();
    lat = 2;
    for (int i = 0; i < 4; i++) begin
      q0.push_back(imul_req_mk(IMUL_FUNC_MUL, 32'(i + 1), 32'(i + 10)));
      q1.push_back(imul_req_mk(IMUL_FUNC_MUL, 32'(i + 100), 32'(3 * i + 7)));
    end
    en0 = 1'b1; en1 = 1'b1;
    drive();
    run(300);
`ifdef PLAB1_IMUL_ARB_ROUND_ROBIN_EN
    check_order("contend", '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
`else
    check_order("contend", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1});
`endif
  endtask

  task automatic test_grant_latch();
    do_reset();
    m_in_en = 1'b0;
    q1.push_back(imul_req_mk(IMUL_FUNC_MUL, 32'd9, 32'd9));
    en1 = 1'b1;
    drive();
    repeat (3) cycle();
    q0.push_back(imul_req_mk(IMUL_FUNC_MUL, 32'd2, 32'd3));
    en0 = 1'b1;
    drive();
    repeat (3) begin
      cycle();
      #2;
      total++;
      if ({mul_in_val, mul_domain, req0_rdy, req1_rdy} !== 4'b1100) begin
        bad++; $display("FAIL grant_latch: got %b want 1100", {mul_in_val, mul_domain, req0_rdy, req1_rdy});
      end
    end
    m_in_en = 1'b1;
    run(100);
    check_order("latch", '{1'b1, 1'b0});
  endtask

  task automatic test_back_pressure();
    int unsigned n = 0;
    do_reset();
    lat = 2;
    resp1_rdy = 1'b0;
    q1.push_back(imul_req_mk(IMUL_FUNC_MUL, 32'hFFFF_FFFF, 32'd2));
    en1 = 1'b1;
    drive();
    while (!resp1_val && n < 50) begin
      cycle();
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++; $display("FAIL bp_wait: got no resp1_val in %0d cycles want resp1_val", n);
    end
    q0.push_back(imul_req_mk(IMUL_FUNC_MUL, 32'd1, 32'd1));
    en0 = 1'b1;
    drive();
    repeat (10) begin
      cycle();
      #2;
      total++;
      if ({resp1_val, resp1_msg, mul_in_val, req0_rdy} !== {1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0}) begin
        bad++; $display("FAIL bp_hold: got %b/%h/%b/%b want 1/fffffffe/0/0", resp1_val, resp1_msg, mul_in_val, req0_rdy);
      end
    end
    resp1_rdy = 1'b1;
    run(100);
    check_order("bp", '{1'b1, 1'b0});
  endtask

  task automatic test_reset_mid_busy();
    int unsigned n = 0;
    do_reset();
    lat = 8;
    q1.push_back(imul_req_mk(IMUL_FUNC_MUL, 32'd7, 32'd7));
    en1 = 1'b1;
    drive();
    while (!outstanding && n < 20) begin
      cycle();
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++; $display("FAIL midrst_issue: got no issue in %0d cycles want issue", n);
    end
    repeat (2) cycle();
    reset = 1'b0;
    en1 = 1'b0; q1.delete(); exp1.delete();
    outstanding = 1'b0; tb_owner = 1'b0;
    drive();
    #1;
    total++;
    if ({resp1_val, mul_out_rdy, mul_domain} !== 3'b000) begin
      bad++; $display("FAIL midrst_out: got %b want 000", {resp1_val, mul_out_rdy, mul_domain});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) cycle();
    lat = 1;
    q0.push_back(imul_req_mk(IMUL_FUNC_MUL, 32'd2, 32'd2));
    en0 = 1'b1;
    drive();
    run(100);
    check_order("midrst", '{1'b0});
  endtask

  task automatic test_stray();
    do_reset();
    stray = 1'b1;
    repeat (5) cycle();
    stray = 1'b0;
    repeat (2) cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    en0 = 1'b0; en1 = 1'b0; stray = 1'b0; m_in_en = 1'b1; lat = 1;
    resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    outstanding = 1'b0; tb_owner = 1'b0;
    drive();
    test_reset();
    test_single();
    test_simultaneous();
    test_contention();
    test_grant_latch();
    test_back_pressure();
    test_reset_mid_busy();
    test_stray();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
